// File: rtl/sha256_w_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sha256_w_sched_ctrl
// Description : SHA-256 message-schedule sequencer. It holds a 16-word sliding
//               window and streams W_0..W_(ROUNDS-1) over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_w_sched_ctrl #(
    parameter int ROUNDS = 64
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] block_in,
    input  logic         abort,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_out,
    output logic [6:0]   w_round,
    output logic         w_last,
    output logic         done,
    output logic         busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [6:0] c_LAST_T = 7'(ROUNDS - 1);

    state_t      state_q, state_d;
    logic [6:0]  t_q, t_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic        done_q, done_d;

    logic        w_run;
    logic        w_beat;
    logic        w_is_last;
    logic        w_load;
    logic [31:0] w_new_word;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign w_run      = (state_q == ST_RUN);
    assign w_beat     = w_run & w_ready;
    assign w_is_last  = (t_q == c_LAST_T);
    assign w_new_word = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

    // Ready on the final beat too, so a waiting block chains with no bubble.
    assign in_ready = ~RST & (~w_run | (w_beat & w_is_last));
    assign w_load   = in_valid & in_ready;

    assign w_valid = w_run;
    assign w_out   = w_run ? win_q[0] : 32'd0;
    assign w_round = w_run ? t_q : 7'd0;
    assign w_last  = w_run & w_is_last;
    assign busy    = w_run;
    assign done    = done_q;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        done_d  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            win_d[i] = win_q[i];
        end

        if (abort) begin
            state_d = ST_IDLE;
            t_d     = 7'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_load) begin
                        for (int i = 0; i < 16; i++) begin
                            win_d[i] = block_in[511 - 32*i -: 32];
                        end
                        t_d     = 7'd0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_beat) begin
                        if (w_is_last) begin
                            done_d = 1'b1;
                            t_d    = 7'd0;
                            if (w_load) begin
                                for (int i = 0; i < 16; i++) begin
                                    win_d[i] = block_in[511 - 32*i -: 32];
                                end
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            for (int i = 0; i < 15; i++) begin
                                win_d[i] = win_q[i + 1];
                            end
                            win_d[15] = w_new_word;
                            t_d       = t_q + 7'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            t_q     <= 7'd0;
            done_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            done_q  <= done_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_w_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_w_sched_ctrl
// Description : Directed bench for the SHA-256 schedule sequencer, with a
//               cycle-level reference model checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_w_sched_ctrl;

    logic         CLK = 1'b0;
    logic         RST;
    logic         in_valid, in_ready, abort, w_valid, w_ready, w_last, done, busy;
    logic [511:0] block_in;
    logic [31:0]  w_out;
    logic [6:0]   w_round;

    logic         in_valid_b, in_ready_b, abort_b, w_valid_b, w_ready_b;
    logic         w_last_b, done_b, busy_b;
    logic [31:0]  w_out_b;
    logic [6:0]   w_round_b;

    always #5 CLK = ~CLK;

    sha256_w_sched_ctrl #(.ROUNDS(64)) u_dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .block_in(block_in), .abort(abort), .w_valid(w_valid), .w_ready(w_ready),
        .w_out(w_out), .w_round(w_round), .w_last(w_last), .done(done), .busy(busy)
    );

    sha256_w_sched_ctrl #(.ROUNDS(16)) u_dut16 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .block_in(block_in), .abort(abort_b), .w_valid(w_valid_b), .w_ready(w_ready_b),
        .w_out(w_out_b), .w_round(w_round_b), .w_last(w_last_b), .done(done_b), .busy(busy_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Full schedule from the textbook recurrence over an array of W values.
    function automatic logic [31:0] sched_word(input logic [511:0] blk, input int idx);
        logic [31:0] w [64];
        logic [31:0] s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        return w[idx];
    endfunction

    logic         mon_en = 1'b0;
    logic [31:0]  got [64];
    int           done_cnt = 0;

    // Reference model: protocol-level state, compared on every falling edge.
    initial begin : p_model
        bit           m_run;
        int           m_t;
        bit           m_done;
        logic [511:0] m_blk;
        bit           beat, lastb, exp_rdy;
        m_run = 0; m_t = 0; m_done = 0; m_blk = '0;
        wait (mon_en);
        forever begin
            @(negedge CLK);
            exp_rdy = !RST && (!m_run || (w_ready && m_t == 63));
            chk("w_valid",  w_valid, m_run);
            chk("w_out",    w_out,   m_run ? sched_word(m_blk, m_t) : 32'd0);
            chk("w_round",  w_round, m_run ? 7'(m_t) : 7'd0);
            chk("w_last",   w_last,  m_run && m_t == 63);
            chk("busy",     busy,    m_run);
            chk("done",     done,    m_done);
            chk("in_ready", in_ready, exp_rdy);
            if (w_valid && w_ready) got[w_round[5:0]] = w_out;
            if (done) done_cnt++;
            if (RST || abort) begin
                m_run = 0; m_t = 0; m_done = 0;
            end else begin
                beat   = m_run && w_ready;
                lastb  = beat && m_t == 63;
                m_done = lastb;
                if ((!m_run || lastb) && in_valid) begin
                    m_blk = block_in; m_t = 0; m_run = 1;
                end else if (lastb) begin
                    m_run = 0; m_t = 0;
                end else if (beat) begin
                    m_t++;
                end
            end
        end
    end

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input int max);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!in_ready && n < max);
        if (!in_ready) chk("accept_timeout", in_ready, 1'b1);
    endtask

    task automatic send_block(input logic [511:0] blk);
        block_in = blk;
        in_valid = 1'b1;
        wait_ready(200);
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int max, input bit toggle);
        int n = 0;
        do begin
            @(posedge CLK); #1;
            if (toggle) w_ready = 1'($urandom_range(0, 1));
            n++;
        end while (!done && n < max);
        if (!done) chk("done_timeout", done, 1'b1);
        w_ready = 1'b1;
    endtask

    task automatic wait_round(input int r);
        int n = 0;
        do begin
            @(posedge CLK); #1;
            n++;
        end while (!(w_valid && w_round == 7'(r)) && n < 200);
        if (!(w_valid && w_round == 7'(r))) chk("round_timeout", w_round, 7'(r));
    endtask

    logic [511:0] abc, blk_b;
    logic [31:0]  ref1 [64];
    logic [31:0]  e16;
    int           d0, cnt16, dn16, last16;
    bit           acc16;

    initial begin : p_drive
        abc = '0;
        abc[511:480] = 32'h61626380;
        abc[31:0]    = 32'h00000018;
        for (int i = 0; i < 16; i++) blk_b[511 - 32*i -: 32] = 32'h01010101 * (i + 1);

        RST = 1'b1; in_valid = 1'b0; abort = 1'b0; w_ready = 1'b0; block_in = '0;
        in_valid_b = 1'b0; abort_b = 1'b0; w_ready_b = 1'b0;
        repeat (2) @(posedge CLK);
        #1 mon_en = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;

        // Pin the model with hand-computed "abc" schedule words.
        chk("model_W16", sched_word(abc, 16), 32'h61626380);
        chk("model_W17", sched_word(abc, 17), 32'h000F0000);
        chk("model_W18", sched_word(abc, 18), 32'h7DA86405);
        chk("model_W63", sched_word(abc, 63), 32'h12B1EDEB);

        // 1: abc block, consumer always ready
        w_ready = 1'b1;
        send_block(abc);
        wait_done(200, 1'b0);
        chk("t1_W0",  got[0],  32'h61626380);
        chk("t1_W16", got[16], 32'h61626380);
        chk("t1_W17", got[17], 32'h000F0000);
        chk("t1_W18", got[18], 32'h7DA86405);
        chk("t1_W63", got[63], 32'h12B1EDEB);
        for (int i = 0; i < 64; i++) begin
            ref1[i] = got[i];
            got[i]  = '0;
        end

        // 2: same block, pseudo-random stalls
        send_block(abc);
        wait_done(2000, 1'b1);
        for (int i = 0; i < 64; i++) chk($sformatf("t2_W%0d", i), got[i], ref1[i]);

        // 3: two blocks chained with in_valid held high
        repeat (2) @(posedge CLK);
        #1 d0 = done_cnt;
        block_in = abc;
        in_valid = 1'b1;
        wait_ready(200);
        @(posedge CLK); #1;
        block_in = blk_b;
        wait_ready(200);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        wait_done(200, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        chk("t3_done_pulses", done_cnt - d0, 2);
        chk("t3_B_W0", got[0], 32'h01010101);
        chk("t3_B_W15", got[15], 32'h10101010);

        // 4: abort at t=20
        send_block(abc);
        wait_round(20);
        d0 = done_cnt;
        abort = 1'b1;
        @(posedge CLK); #1;
        abort = 1'b0;
        chk("t4_w_valid", w_valid, 1'b0);
        chk("t4_in_ready", in_ready, 1'b1);
        chk("t4_done", done, 1'b0);
        repeat (3) @(posedge CLK);
        #1 chk("t4_no_done", done_cnt - d0, 0);
        send_block(blk_b);
        wait_done(200, 1'b0);
        chk("t4_B_W0", got[0], 32'h01010101);

        // 5: reset mid-block at t=40 with a new block offered
        send_block(abc);
        wait_round(40);
        RST = 1'b1; in_valid = 1'b1; block_in = blk_b;
        @(posedge CLK); #1;
        chk("t5_in_ready_rst", in_ready, 1'b0);
        chk("t5_w_valid_rst", w_valid, 1'b0);
        chk("t5_w_out_rst", w_out, 32'd0);
        chk("t5_busy_rst", busy, 1'b0);
        @(posedge CLK); #1;
        RST = 1'b0;
        #1 chk("t5_in_ready_after", in_ready, 1'b1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        wait_done(200, 1'b0);

        // 6: ROUNDS=16 instance emits only the loaded words
        cnt16 = 0; dn16 = 0; last16 = -1; acc16 = 0;
        block_in = abc; in_valid_b = 1'b1; w_ready_b = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (in_valid_b && in_ready_b) acc16 = 1;
            if (w_valid_b && w_ready_b) begin
                e16 = (w_round_b == 7'd0) ? 32'h61626380 :
                      (w_round_b == 7'd15) ? 32'h00000018 : 32'd0;
                chk($sformatf("t6_W%0d", w_round_b), w_out_b, e16);
                chk("t6_last", w_last_b, w_round_b == 7'd15);
                if (w_last_b) last16 = int'(w_round_b);
                cnt16++;
            end
            if (done_b) dn16++;
            @(posedge CLK); #1;
            if (acc16) in_valid_b = 1'b0;
        end
        chk("t6_count", cnt16, 16);
        chk("t6_done", dn16, 1);
        chk("t6_last_round", last16, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
